// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Holds the ALU operation codes this unit consumes, the FSM state
// encodings, and small helpers for classifying an alucode.
package load_store_unit_pkg;

  // ALU operation codes (6-bit), as produced by the decoder.
  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;
  localparam logic [5:0] ALU_ADD = 6'd17;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] code);
    return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
           (code == ALU_LBU) || (code == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] code);
    return is_load(code) || is_store(code);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational data steering for the load/store unit.
// Ports:
//   alucode    in  6   memory operation
//   addr_lo    in  2   byte offset within the word
//   store_data in  32  rs2 value for stores
//   rdata      in  32  word read from memory
//   we         out 1   1 for stores
//   wstrb      out 4   byte-lane write enables
//   wdata      out 32  store data replicated onto every lane it may hit
//   load_ext   out 32  extracted and sign/zero-extended load value
//   misaligned out 1   access crosses its natural alignment
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        we,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    we         = 1'b0;
    wstrb      = 4'b0000;
    wdata      = store_data;
    load_ext   = rdata;
    misaligned = 1'b0;
    case (alucode)
      ALU_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      ALU_LBU: load_ext = {24'h000000, byte_sel};
      ALU_LH: begin
        load_ext   = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      ALU_LHU: begin
        load_ext   = {16'h0000, half_sel};
        misaligned = addr_lo[0];
      end
      ALU_LW: misaligned = (addr_lo != 2'b00);
      ALU_SB: begin
        we    = 1'b1;
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      ALU_SH: begin
        we         = 1'b1;
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      ALU_SW: begin
        we         = 1'b1;
        wstrb      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit.
// Accepts a memory op from execute, issues one request/acknowledge
// transaction on the data port, and returns extended load data.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   start, alucode, addr,
//   store_data                  op presented by execute
//   busy                        pipeline stall while an access is in flight
//   done, load_data, misaligned completion pulse and its results
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata        registered request to data memory
//   mem_ack, mem_rdata          single-cycle acknowledge and read word
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        alucode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state_reg, state_next;

  logic [5:0]        op_reg;
  logic [1:0]        addr_lo_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [3:0]        mem_wstrb_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       load_data_reg;
  logic              misaligned_reg;

  logic        accept;
  logic [5:0]  align_op;
  logic [1:0]  align_lo;
  logic        align_we;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        align_mis;

  assign accept = start && (state_reg == LSU_IDLE) && is_mem_op(alucode);

  // One aligner serves both phases: in IDLE it looks at the incoming op to
  // build the request and judge alignment; afterwards it looks at the
  // captured op so the load extract uses the offset of the pending access.
  assign align_op = (state_reg == LSU_IDLE) ? alucode   : op_reg;
  assign align_lo = (state_reg == LSU_IDLE) ? addr[1:0] : addr_lo_reg;

  lsu_align u_align (
    .alucode    (align_op),
    .addr_lo    (align_lo),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .we         (align_we),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .load_ext   (align_load),
    .misaligned (align_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LSU_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: if (accept) state_next = align_mis ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (mem_ack) state_next = LSU_DONE;
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg         <= '0;
      addr_lo_reg    <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wstrb_reg  <= '0;
      mem_wdata_reg  <= '0;
      load_data_reg  <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg         <= alucode;
        addr_lo_reg    <= addr[1:0];
        misaligned_reg <= align_mis;
        if (!align_mis) begin
          mem_req_reg   <= 1'b1;
          mem_we_reg    <= align_we;
          mem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
          mem_wstrb_reg <= align_wstrb;
          mem_wdata_reg <= align_wdata;
        end else if (is_load(alucode)) begin
          // A refused load still completes, with a defined zero result.
          load_data_reg <= '0;
        end
      end
      if ((state_reg == LSU_REQ) && mem_ack) begin
        mem_req_reg <= 1'b0;
        if (is_load(op_reg)) load_data_reg <= align_load;
      end
    end
  end

  assign busy       = (state_reg != LSU_IDLE);
  assign done       = (state_reg == LSU_DONE);
  assign load_data  = load_data_reg;
  assign misaligned = misaligned_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wstrb  = mem_wstrb_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of transactions is
// driven back to back, expected results go into a scoreboard queue at
// issue and are compared when done is seen. Hand-written sequences cover
// ignored starts and reset in the middle of an access.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alucode    (alucode),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          dly;       // ack in this request cycle; 0 = no request expected
    bit          poke;      // issue a stray start while the request is pending
    logic [31:0] exp_maddr;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic        exp_mis;
    int          exp_lat;   // cycles from start to done
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int dly, input bit poke,
                              input logic [31:0] maddr, input logic we, input logic [3:0] strb,
                              input logic [31:0] wd, input logic [31:0] ld, input logic mis,
                              input int lat);
    vec_t v;
    v.op = op; v.addr = a; v.sd = sd; v.rdata = rd; v.dly = dly; v.poke = poke;
    v.exp_maddr = maddr; v.exp_we = we; v.exp_strb = strb; v.exp_wdata = wd;
    v.exp_load = ld; v.exp_mis = mis; v.exp_lat = lat;
    return v;
  endfunction

  // Entered and left on a falling edge; the next transaction may start in
  // the very cycle this one returns (first cycle with busy low).
  task automatic run_vec(input vec_t v);
    int   reqc = 0;
    bit   got  = 1'b0;
    vec_t e;
    alucode = v.op; addr = v.addr; store_data = v.sd; start = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      mem_ack = 1'b0;
      start   = 1'b0;
      if (mem_req) begin
        reqc++;
        chk("req_fields", {mem_addr, 27'd0, mem_we, mem_wstrb},
            {v.exp_maddr, 27'd0, v.exp_we, v.exp_strb});
        chk("req_busy", {63'd0, busy}, 64'd1);
        if (v.exp_we) chk("req_wdata", {32'd0, mem_wdata}, {32'd0, v.exp_wdata});
        if (v.poke && reqc == 2) begin
          start = 1'b1; alucode = ALU_SW; addr = 32'h0000_0200;
        end
        if (reqc == v.dly) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end
      end
      if (done) begin
        got = 1'b1;
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard: done with no pending transaction");
        end else begin
          e = sb_q.pop_front();
          chk("load_data", {32'd0, load_data}, {32'd0, e.exp_load});
          chk("misaligned", {63'd0, misaligned}, {63'd0, e.exp_mis});
          chk("latency", 64'(cyc), 64'(e.exp_lat));
          chk("req_cycles", 64'(reqc), 64'(e.dly));
          chk("done_state", {62'd0, busy, mem_req}, {62'd0, 1'b1, 1'b0});
          $display("txn op=%0d addr=%h load_data=%h misaligned=%0b latency=%0d",
                   e.op, e.addr, load_data, misaligned, cyc);
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    start   = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL done_timeout: got no done expected done for op %0d", v.op);
      void'(sb_q.pop_front());
    end
    chk("idle_after", {62'd0, busy, done}, 64'd0);
    if (v.poke) begin
      repeat (4) begin
        @(negedge clk);
        chk("stray_start", {61'd0, busy, done, mem_req}, 64'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alucode = '0; addr = '0; store_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //              op       addr          sd            rdata         dly poke maddr        we  strb     wdata         load          mis lat
    vecs.push_back(mk(ALU_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 32'h100, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 2));
    vecs.push_back(mk(ALU_SB,  32'h103, 32'h000000A5, 32'h0,        1, 0, 32'h100, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 2));
    vecs.push_back(mk(ALU_SH,  32'h102, 32'h00001234, 32'h0,        1, 0, 32'h100, 1, 4'b1100, 32'h12341234, 32'h0,        0, 2));
    vecs.push_back(mk(ALU_LB,  32'h101, 32'h0,        32'h00008000, 1, 0, 32'h100, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk(ALU_LBU, 32'h101, 32'h0,        32'h00008000, 2, 0, 32'h100, 0, 4'b0000, 32'h0,        32'h00000080, 0, 3));
    vecs.push_back(mk(ALU_LH,  32'h102, 32'h0,        32'h80010000, 1, 0, 32'h100, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0, 2));
    vecs.push_back(mk(ALU_LHU, 32'h102, 32'h0,        32'h80010000, 1, 0, 32'h100, 0, 4'b0000, 32'h0,        32'h00008001, 0, 2));
    vecs.push_back(mk(ALU_SB,  32'h100, 32'h11223344, 32'h0,        1, 0, 32'h100, 1, 4'b0001, 32'h44444444, 32'h00008001, 0, 2));
    vecs.push_back(mk(ALU_LW,  32'h102, 32'h0,        32'h12345678, 0, 0, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk(ALU_LW,  32'h108, 32'h0,        32'hCAFEF00D, 5, 1, 32'h108, 0, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 6));
    vecs.push_back(mk(ALU_LH,  32'h101, 32'h0,        32'h0,        0, 0, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk(ALU_SH,  32'h10D, 32'h0000BEEF, 32'h0,        0, 0, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk(ALU_LB,  32'h102, 32'h0,        32'h007F0000, 1, 0, 32'h100, 0, 4'b0000, 32'h0,        32'h0000007F, 0, 2));
    vecs.push_back(mk(ALU_SW,  32'h10C, 32'h0BADF00D, 32'h0,        3, 0, 32'h10C, 1, 4'b1111, 32'h0BADF00D, 32'h0000007F, 0, 4));
    vecs.push_back(mk(ALU_SH,  32'h200, 32'h0000ABCD, 32'h0,        1, 0, 32'h200, 1, 4'b0011, 32'hABCDABCD, 32'h0000007F, 0, 2));

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {59'd0, busy, done, misaligned, mem_req, mem_we}, 64'd0);
    chk("reset_addr", {32'd0, mem_addr}, 64'd0);
    chk("reset_strb_wdata", {28'd0, mem_wstrb, mem_wdata}, 64'd0);
    chk("reset_load_data", {32'd0, load_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // A non-memory op is ignored.
    alucode = ALU_ADD; addr = 32'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_nonmem", {62'd0, busy, mem_req}, 64'd0);
    $display("txn op=%0d ignored busy=%0b", ALU_ADD, busy);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a load is waiting for its acknowledge.
    alucode = ALU_LW; addr = 32'h400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_req", {63'd0, mem_req}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ctrl", {59'd0, busy, done, misaligned, mem_req, mem_we}, 64'd0);
    chk("rst_mid_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mid_strb_wdata", {28'd0, mem_wstrb, mem_wdata}, 64'd0);
    chk("rst_mid_load", {32'd0, load_data}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_1", {61'd0, busy, done, mem_req}, 64'd0);
    @(negedge clk);
    chk("late_ack_2", {29'd0, busy, done, mem_req, load_data}, 64'd0);
    $display("txn reset mid-access busy=%0b done=%0b mem_req=%0b", busy, done, mem_req);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
